// File: rtl/redmule_tb_mmio.sv
`default_nettype none
// ============================================================================
// Module      : redmule_tb_mmio
// Description : Test-control peripheral for the RedMulE simulation harness.
//               Captures the end-of-test exit code, buffers console characters
//               in a FIFO drained by a host-side consumer, and provides an
//               optional start/stop cycle counter.
//               Optional feature macro: REDMULE_TB_MMIO_PERF_EN (cycle counter).
// Revision    : 1.0 - initial release
// ============================================================================
module redmule_tb_mmio #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_code_o,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    localparam logic [5:0] OFF_EXIT      = 6'd0;
    localparam logic [5:0] OFF_PUTC      = 6'd1;
    localparam logic [5:0] OFF_PERF_CTRL = 6'd2;
    localparam logic [5:0] OFF_PERF_CNT  = 6'd3;
    localparam logic [5:0] OFF_STATUS    = 6'd4;

    // Region selection happens upstream; only the word offset is decoded here.
    logic [5:0] offset;
    logic       unused_addr;
    assign offset      = addr_i[7:2];
    assign unused_addr = ^{addr_i[31:8], addr_i[1:0]};

    logic              wr_access;
    logic              putc_wr;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic [7:0]        fifo_count8;

    // Full check uses the registered count: a same-cycle pop never unblocks a push.
    assign fifo_full    = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    assign putc_wr      = req_i & we_i & (offset == OFF_PUTC);
    assign gnt_o        = req_i & ~(putc_wr & fifo_full);
    assign wr_access    = gnt_o & we_i;
    assign push         = wr_access & (offset == OFF_PUTC);
    assign char_valid_o = (fifo_cnt != '0);
    assign pop          = char_valid_o & char_ready_i;
    assign char_data_o  = char_valid_o ? mem[rd_ptr] : 8'h00;
    assign fifo_count8  = 8'(fifo_cnt);

    // Character FIFO: circular buffer, no bypass from push to head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata_i[7:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Exit code: byte-merged write; any EXIT write (even be=0) marks it valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exit_valid_o <= 1'b0;
            exit_code_o  <= 32'h0;
        end else if (wr_access && (offset == OFF_EXIT)) begin
            exit_valid_o <= 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    exit_code_o[8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    logic        running_s;
    logic        ovf_s;
    logic [31:0] cnt_rd;

`ifdef REDMULE_TB_MMIO_PERF_EN
    logic             running;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    assign running_s = running;
    assign ovf_s     = ovf;
    assign cnt_rd    = 32'(cnt);

    // Cycle counter: a clear write wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running <= 1'b0;
            ovf     <= 1'b0;
            cnt     <= '0;
        end else begin
            if (wr_access && (offset == OFF_PERF_CTRL)) begin
                running <= wdata_i[0];
            end
            if (wr_access && (offset == OFF_PERF_CNT)) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (running) begin
                cnt <= cnt + 1'b1;
                if (&cnt) begin
                    ovf <= 1'b1;
                end
            end
        end
    end
`else
    assign running_s = 1'b0;
    assign ovf_s     = 1'b0;
    assign cnt_rd    = 32'h0;
`endif

    logic [31:0] rd_mux;

    // Read mux from the state present at grant time.
    always_comb begin
        rd_mux = 32'h0;
        case (offset)
            OFF_EXIT:      rd_mux = exit_code_o;
            OFF_PERF_CTRL: rd_mux = {31'h0, running_s};
            OFF_PERF_CNT:  rd_mux = cnt_rd;
            OFF_STATUS:    rd_mux = {16'h0, fifo_count8, 5'h0, ovf_s, exit_valid_o, running_s};
            default:       rd_mux = 32'h0;
        endcase
    end

    // One registered response per granted request; write responses carry 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= 32'h0;
        end else begin
            rvalid_o <= gnt_o;
            rdata_o  <= (gnt_o && !we_i) ? rd_mux : 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_redmule_tb_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_redmule_tb_mmio
// Description : Self-checking bench for redmule_tb_mmio with a queue-based
//               reference model; counter checks active with
//               REDMULE_TB_MMIO_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_redmule_tb_mmio;

    localparam int unsigned DEPTH = 8;
`ifdef REDMULE_TB_MMIO_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;

    redmule_tb_mmio #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .gnt_o        (gnt),
        .addr_i       (addr),
        .we_i         (we),
        .be_i         (be),
        .wdata_i      (wdata),
        .rdata_o      (rdata),
        .rvalid_o     (rvalid),
        .exit_valid_o (exit_valid),
        .exit_code_o  (exit_code),
        .char_valid_o (char_valid),
        .char_data_o  (char_data),
        .char_ready_i (char_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state
    logic [7:0]  q[$];
    logic [31:0] m_code;
    logic        m_ev;
    logic        m_run;
    logic        m_ovf;
    logic [15:0] m_cnt;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_code = 32'h0; m_ev = 1'b0; m_run = 1'b0; m_ovf = 1'b0; m_cnt = 16'h0;
        exp_rvalid = 1'b0; exp_rdata = 32'h0;
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] off);
        logic [31:0] v;
        logic [7:0]  n;
        n = 8'(q.size());
        case (off)
            6'd0:    v = m_code;
            6'd2:    v = PERF ? {31'h0, m_run} : 32'h0;
            6'd3:    v = PERF ? {16'h0, m_cnt} : 32'h0;
            6'd4:    v = {16'h0, n, 5'h0, PERF & m_ovf, m_ev, PERF & m_run};
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // One bus cycle: drive, check outputs mid-cycle, then advance the model.
    task automatic step(input bit rq, input logic [5:0] off, input bit wr, input logic [3:0] bm,
                        input logic [31:0] wd, input bit rdy, output bit granted);
        bit          eg;
        logic [31:0] rv;
        req = rq; addr = {24'h0, off, 2'b00}; we = wr; be = bm; wdata = wd; char_ready = rdy;
        @(negedge clk);
        eg = rq && !(wr && off == 6'd1 && q.size() == DEPTH);
        chk("gnt", {31'h0, gnt}, {31'h0, eg});
        chk("rvalid", {31'h0, rvalid}, {31'h0, exp_rvalid});
        chk("rdata", rdata, exp_rdata);
        chk("char_valid", {31'h0, char_valid}, {31'h0, q.size() != 0});
        chk("char_data", {24'h0, char_data}, {24'h0, (q.size() != 0) ? q[0] : 8'h00});
        chk("exit_valid", {31'h0, exit_valid}, {31'h0, m_ev});
        chk("exit_code", exit_code, m_code);
        rv = model_read(off);
        @(posedge clk);
        #1;
        exp_rvalid = eg;
        exp_rdata  = (eg && !wr) ? rv : 32'h0;
        if (PERF) begin
            if (eg && wr && off == 6'd3) begin
                m_cnt = 16'h0; m_ovf = 1'b0;
            end else if (m_run) begin
                if (m_cnt == 16'hFFFF) m_ovf = 1'b1;
                m_cnt = m_cnt + 16'd1;
            end
            if (eg && wr && off == 6'd2) m_run = wd[0];
        end
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (eg && wr && off == 6'd1) q.push_back(wd[7:0]);
        if (eg && wr && off == 6'd0) begin
            m_ev = 1'b1;
            for (int b = 0; b < 4; b++) if (bm[b]) m_code[8*b +: 8] = wd[8*b +: 8];
        end
        granted = eg;
    endtask

    task automatic idle(input bit rdy);
        bit g;
        step(1'b0, 6'd0, 1'b0, 4'h0, 32'h0, rdy, g);
    endtask

    initial begin
        bit          g;
        int          tries;
        logic [5:0]  off;
        bit          wr;
        logic [3:0]  bm;
        logic [31:0] wd;

        rst_n = 1'b0; req = 1'b0; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0; char_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rvalid", {31'h0, rvalid}, 32'h0);
        chk("reset_exit_valid", {31'h0, exit_valid}, 32'h0);
        chk("reset_char_valid", {31'h0, char_valid}, 32'h0);
        rst_n = 1'b1;

        // EXIT = 0 with full byte enables
        step(1'b1, 6'd0, 1'b1, 4'hF, 32'h0, 1'b0, g);
        idle(1'b0);
        chk("exit_valid_after_zero", {31'h0, exit_valid}, 32'h1);

        // Byte-merged EXIT write and readback
        step(1'b1, 6'd0, 1'b1, 4'hF, 32'h1234_5678, 1'b0, g);
        step(1'b1, 6'd0, 1'b1, 4'h3, 32'hAABB_CCDD, 1'b0, g);
        step(1'b1, 6'd0, 1'b0, 4'hF, 32'h0, 1'b0, g);
        chk("exit_merge_read", rdata, 32'h1234_CCDD);
        idle(1'b0);

        // Fill FIFO with 'A'..'H', ninth write 'I' stalls until a pop frees space
        for (int i = 0; i < 8; i++) step(1'b1, 6'd1, 1'b1, 4'h0, 32'h41 + i, 1'b0, g);
        step(1'b1, 6'd1, 1'b1, 4'hF, 32'h49, 1'b0, g);
        chk("ninth_stalled", {31'h0, g}, 32'h0);
        step(1'b1, 6'd1, 1'b1, 4'hF, 32'h49, 1'b1, g);
        chk("ninth_same_cycle_pop", {31'h0, g}, 32'h0);
        step(1'b1, 6'd1, 1'b1, 4'hF, 32'h49, 1'b1, g);
        chk("ninth_granted", {31'h0, g}, 32'h1);
        repeat (9) idle(1'b1);

        // Simultaneous push and pop with three queued
        for (int i = 0; i < 3; i++) step(1'b1, 6'd1, 1'b1, 4'hF, 32'h61 + i, 1'b0, g);
        step(1'b1, 6'd1, 1'b1, 4'hF, 32'h64, 1'b1, g);
        step(1'b1, 6'd4, 1'b0, 4'hF, 32'h0, 1'b0, g);
        chk("status_count3", {24'h0, rdata[15:8]}, 32'h3);
        repeat (4) idle(1'b1);

        // Randomized traffic; stalled requests are held until granted
        for (int n = 0; n < 400; n++) begin
            off = ($urandom_range(0, 7) == 7) ? 6'($urandom_range(5, 63)) : 6'($urandom_range(0, 4));
            if (off == 6'd1 && $urandom_range(0, 1) == 1) off = 6'd1;
            wr  = $urandom_range(0, 1) == 1;
            bm  = 4'($urandom);
            wd  = $urandom;
            if (off == 6'd2 && wr) wd[0] = $urandom_range(0, 3) != 0;
            tries = 0;
            do begin
                step($urandom_range(0, 4) != 0, off, wr, bm, wd, $urandom_range(0, 2) == 0, g);
                tries++;
            end while (req && !g && tries < 60);
            if (req) chk("stall_bound", {31'h0, g}, 32'h1);
        end
        repeat (10) idle(1'b1);

        // Counter: start, 99 idle cycles, stop -> 100 increments
        step(1'b1, 6'd2, 1'b1, 4'hF, 32'h0, 1'b1, g);
        step(1'b1, 6'd3, 1'b1, 4'hF, 32'h0, 1'b1, g);
        step(1'b1, 6'd2, 1'b1, 4'hF, 32'h1, 1'b1, g);
        repeat (99) idle(1'b1);
        step(1'b1, 6'd2, 1'b1, 4'hF, 32'h0, 1'b1, g);
        step(1'b1, 6'd3, 1'b0, 4'hF, 32'h0, 1'b1, g);
`ifdef REDMULE_TB_MMIO_PERF_EN
        chk("perf_cnt_100", rdata, 32'd100);
`else
        chk("perf_cnt_absent", rdata, 32'd0);
`endif
        idle(1'b1);

`ifdef REDMULE_TB_MMIO_PERF_EN
        // Wrap past 65535, then clear
        step(1'b1, 6'd2, 1'b1, 4'hF, 32'h1, 1'b1, g);
        repeat (65540) idle(1'b1);
        step(1'b1, 6'd2, 1'b1, 4'hF, 32'h0, 1'b1, g);
        step(1'b1, 6'd4, 1'b0, 4'hF, 32'h0, 1'b1, g);
        chk("status_ovf", {31'h0, rdata[2]}, 32'h1);
        step(1'b1, 6'd3, 1'b1, 4'hF, 32'h0, 1'b1, g);
        step(1'b1, 6'd3, 1'b0, 4'hF, 32'h0, 1'b1, g);
        chk("cnt_cleared", rdata, 32'h0);
        step(1'b1, 6'd4, 1'b0, 4'hF, 32'h0, 1'b1, g);
        chk("ovf_cleared", {31'h0, rdata[2]}, 32'h0);
        idle(1'b1);
`endif

        // Reset mid-stream with four queued characters and the counter running
        step(1'b1, 6'd2, 1'b1, 4'hF, 32'h1, 1'b0, g);
        for (int i = 0; i < 4; i++) step(1'b1, 6'd1, 1'b1, 4'hF, 32'h30 + i, 1'b0, g);
        req = 1'b0; we = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_exit_valid", {31'h0, exit_valid}, 32'h0);
        chk("midrst_exit_code", exit_code, 32'h0);
        chk("midrst_char_valid", {31'h0, char_valid}, 32'h0);
        chk("midrst_char_data", {24'h0, char_data}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 6'd4, 1'b0, 4'hF, 32'h0, 1'b0, g);
        chk("status_after_reset", rdata, 32'h0);
        chk("rvalid_after_reset", {31'h0, rvalid}, 32'h1);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/redmule_tb_mmio.md
# redmule_tb_mmio

Memory-mapped test-control peripheral hanging off the core data port in the RedMulE simulation harness, alongside the periph, stack and TCDM dummy memories. It captures the end-of-test exit code, buffers console characters in a FIFO drained by a host-side consumer, and provides a start/stop cycle counter for timing RedMulE jobs. Region selection (`addr[31:24] == 8'h80`) is done upstream; this block decodes only the word offset `addr_i[7:2]`.

## Interface
- `FIFO_DEPTH`, default 8: depth of the character FIFO; power of two, minimum 2.
- `CNT_W`, default 32: width of the cycle counter, range 16..32.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  data request, already region-selected.
- `gnt_o`  out  1  grant; combinational from `req_i`, `addr_i`, `we_i` and registered state.
- `addr_i`  in  32  byte address; bits [7:2] are the register offset.
- `we_i`  in  1  1 = write.
- `be_i`  in  4  byte enables.
- `wdata_i`  in  32  write data.
- `rdata_o`  out  32  read data, valid while `rvalid_o` = 1.
- `rvalid_o`  out  1  response valid, one per granted request.
- `exit_valid_o`  out  1  sticky: EXIT has been written.
- `exit_code_o`  out  32  last value written to EXIT.
- `char_valid_o`  out  1  FIFO non-empty.
- `char_data_o`  out  8  FIFO head.
- `char_ready_i`  in  1  consumer pops the head when `char_valid_o` = 1.

## Operation
- Register map, by word offset:
  - 0x00 EXIT (RW): write merges `wdata_i` into `exit_code` byte-wise per `be_i` and sets `exit_valid`. A write with `be_i` = 0 still sets `exit_valid`.
  - 0x04 PUTC (WO): write pushes `wdata_i[7:0]`; `be_i` is ignored. A read returns 0.
  - 0x08 PERF_CTRL (RW): write `wdata_i[0]` = 1 starts the counter, 0 stops it. A read returns `{31'b0, running}`.
  - 0x0C PERF_CNT (RW): a read returns the zero-extended count. Any write clears count and overflow.
  - 0x10 STATUS (RO): `{16'b0, fifo_count[7:0], 5'b0, ovf, exit_valid, running}`.
  - All other offsets: writes are ignored, reads return 0, the request is still granted and answered.
- Grant:
  - `gnt_o` = `req_i`, except a PUTC write while the FIFO is full, which gets `gnt_o` = 0.
  - A stalled request is held by the core until granted.
- Character FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push on a granted PUTC write; pop on `char_valid_o & char_ready_i`.
  - Simultaneous push and pop leave the count unchanged.
  - No bypass: a character pushed into an empty FIFO appears on `char_valid_o` the next cycle.
  - The full check uses the registered count, so a pop in the same cycle does not unblock a push.
- Counter:
  - While `running`, the count increments by 1 every cycle.
  - Wrap from all-ones to 0 sets sticky `ovf`.
  - A start write while already running does not clear the count.
  - A clear write in the same cycle as an increment takes priority: the count becomes 0.

## Timing
- Every granted request gets exactly one response, `rvalid_o` = 1, exactly one cycle after the grant. This applies to writes too. No back-to-back limit: one request per cycle is sustainable.
- `rdata_o` is registered and sampled from the state present at grant time, before that cycle's update. It is 0 when `rvalid_o` = 0 and for write responses.
- Register effects are visible from the cycle after the grant.
- Reset values:
  - `gnt_o` is combinational.
  - `rvalid_o` = 0, `rdata_o` = 0.
  - `exit_valid_o` = 0, `exit_code_o` = 0.
  - `char_valid_o` = 0, `char_data_o` = 0.
  - FIFO empty, counter 0, `running` = 0, `ovf` = 0.
- Reset mid-operation immediately clears all state, including the FIFO contents and any pending `rvalid_o`.

## Configuration
- `REDMULE_TB_MMIO_PERF_EN` defined: the cycle counter, PERF_CTRL, PERF_CNT and STATUS bits `running`/`ovf` are implemented as above.
- Not defined: no counter flops. PERF_CTRL and PERF_CNT read 0 and ignore writes, while still being granted and answered. STATUS bits 0 and 2 read 0.

## Test plan
- Reset, then write EXIT = 0x0000_0000 with `be_i` = 0xF → next cycle `exit_valid_o` = 1, `exit_code_o` = 0; `rvalid_o` pulses 1 cycle after grant.
- Write EXIT = 0x1234_5678 with `be_i` = 0xF, then 0xAABB_CCDD with `be_i` = 0x3 → `exit_code_o` = 0x1234_CCDD; a read of 0x00 returns the same value.
- With `char_ready_i` = 0, push 'A'..'I' (9 writes, FIFO_DEPTH = 8):
  - Ninth write sees `gnt_o` = 0 while held.
  - Raise `char_ready_i` → 'A' pops, then the ninth write is granted one cycle later.
  - Output order is 'A'..'I'.
- Simultaneous push and pop with count = 3 → count stays 3 and STATUS[15:8] = 3.
- With the macro on:
  - Start, wait 100 cycles, stop, read PERF_CNT → 100 ± 1, fixed by the implementation and checked exactly.
  - With `CNT_W` = 16, run past 65535 → count wraps and STATUS bit 2 = 1.
  - A clear write → count 0 and `ovf` 0.
- Assert `rst_ni` low mid-stream with 4 characters queued and `running` = 1 → all outputs go to their reset values immediately; after release, a read of STATUS returns 0.
